// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the accumulator CPU.
// Adds memory wait states with timeout, resumable halt, illegal-opcode trap and a retired count.
module cpu_sequencer #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                run,
    output logic                mem_rd,
    output logic                load_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                load_ac,
    output logic                load_pc,
    output logic                mem_wr,
    output logic [3:0]          phase,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               illegal_q;
    logic               bus_err_q;
    logic [CNT_W-1:0]   count_q;

    logic illegal_c;
    logic is_hlt_c, is_skz_c, is_sto_c, is_jmp_c, aluop_c;
    logic halt_op_c, wait_st_c, stall_c, timeout_c;

    // Opcodes at or above 8 exist only when the field is wider than the base ISA.
    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign illegal_c = |opcode[OPCODE_W-1:3];
        end else begin : g_base_op
            assign illegal_c = 1'b0;
        end
    endgenerate

    assign is_hlt_c  = (opcode == OP_HLT);
    assign is_skz_c  = (opcode == OP_SKZ);
    assign is_sto_c  = (opcode == OP_STO);
    assign is_jmp_c  = (opcode == OP_JMP);
    assign aluop_c   = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_LDA);
    assign halt_op_c = is_hlt_c || illegal_c;

    // Memory phases that must see mem_ready before advancing.
    assign wait_st_c = (state_q == INST_FETCH) ||
                       ((state_q == OP_FETCH) && aluop_c) ||
                       ((state_q == STORE) && is_sto_c);
    assign stall_c   = wait_st_c && !mem_ready;
    assign timeout_c = stall_c && (wait_q == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INST_ADDR;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            wait_q <= '0;
            if (stall_c) begin
                if (timeout_c) begin
                    state_q   <= HALTED;
                    bus_err_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + WAIT_W'(1);
                end
            end else begin
                unique case (state_q)
                    INST_ADDR:  state_q <= INST_FETCH;
                    INST_FETCH: state_q <= INST_LOAD;
                    INST_LOAD:  state_q <= IDLE;
                    IDLE:       state_q <= OP_ADDR;
                    OP_ADDR: begin
                        if (halt_op_c) begin
                            state_q <= HALTED;
                            if (illegal_c) begin
                                illegal_q <= 1'b1;
                            end
                        end else begin
                            state_q <= OP_FETCH;
                        end
                    end
                    OP_FETCH:   state_q <= ALU_OP;
                    ALU_OP:     state_q <= STORE;
                    STORE: begin
                        state_q <= INST_ADDR;
                        count_q <= count_q + CNT_W'(1);
                    end
                    HALTED: begin
                        if (run) begin
                            state_q <= INST_ADDR;
                        end
                    end
                    default:    state_q <= INST_ADDR;
                endcase
            end
        end
    end

    // Datapath strobes decoded from the registered state and current opcode/zero.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = halt_op_c;
            end
            OP_FETCH: mem_rd = aluop_c;
            ALU_OP: begin
                mem_rd  = aluop_c;
                load_ac = aluop_c;
                inc_pc  = is_skz_c && zero;
                load_pc = is_jmp_c;
            end
            STORE: begin
                mem_rd  = aluop_c;
                load_ac = aluop_c;
                inc_pc  = is_jmp_c;
                load_pc = is_jmp_c;
                mem_wr  = is_sto_c;
            end
            HALTED:  halt = 1'b1;
            default: ;
        endcase
    end

    assign phase       = state_q;
    assign illegal_op  = illegal_q;
    assign bus_err     = bus_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model scripts expected per-cycle outputs.
module tb_cpu_sequencer;

    localparam int OPCODE_W = 4;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    localparam int U_NONE = 0;
    localparam int U_ILL  = 1;
    localparam int U_BUS  = 2;
    localparam int U_CNT  = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [OPCODE_W-1:0] opcode;
    logic                zero, mem_ready, run;
    logic                mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [3:0]          phase;
    logic                illegal_op, bus_err;
    logic [CNT_W-1:0]    instr_count;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .OPCODE_W(OPCODE_W),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .run        (run),
        .mem_rd     (mem_rd),
        .load_ir    (load_ir),
        .halt       (halt),
        .inc_pc     (inc_pc),
        .load_ac    (load_ac),
        .load_pc    (load_pc),
        .mem_wr     (mem_wr),
        .phase      (phase),
        .illegal_op (illegal_op),
        .bus_err    (bus_err),
        .instr_count(instr_count)
    );

    typedef struct packed {
        logic [3:0]       ph;
        logic [6:0]       strb;
        logic             ill;
        logic             bus;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_cnt   = 0;
    bit   m_ill   = 1'b0;
    bit   m_bus   = 1'b0;
    int   kill_in = -1;
    bit   killed  = 1'b0;

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic int ro();
        return int'($urandom_range(0, 15));
    endfunction

    // Strobe table {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} per phase.
    function automatic logic [6:0] strobes(int ph, int op, bit z);
        bit alu = (op >= 2) && (op <= 5);
        bit rd = 0, ir = 0, h = 0, ip = 0, la = 0, lp = 0, wr = 0;
        case (ph)
            1: rd = 1;
            2, 3: begin rd = 1; ir = 1; end
            4: begin ip = 1; h = (op == 0) || (op >= 8); end
            5: rd = alu;
            6: begin rd = alu; la = alu; ip = (op == 1) && z; lp = (op == 7); end
            7: begin rd = alu; la = alu; ip = (op == 7); lp = (op == 7); wr = (op == 6); end
            8: h = 1;
            default: ;
        endcase
        return {rd, ir, h, ip, la, lp, wr};
    endfunction

    task automatic drive_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            opcode    = 4'($urandom);
            zero      = rb();
            mem_ready = rb();
            run       = rb();
            m_cnt = 0;
            m_ill = 1'b0;
            m_bus = 1'b0;
            exp_q.push_back('0);
        end
    endtask

    // One clock of stimulus; upd names the model flag that the edge ending this cycle changes.
    task automatic emit(int ph, int op, bit z, bit rdy, bit rn, int upd);
        exp_t e;
        if (killed) return;
        if (kill_in == 0) begin
            kill_in = -1;
            killed  = 1'b1;
            drive_reset();
            return;
        end
        if (kill_in > 0) kill_in--;
        @(negedge clk);
        reset     = 1'b0;
        opcode    = 4'(op);
        zero      = z;
        mem_ready = rdy;
        run       = rn;
        e.ph   = 4'(ph);
        e.strb = strobes(ph, op, z);
        e.ill  = m_ill;
        e.bus  = m_bus;
        e.cnt  = CNT_W'(m_cnt);
        exp_q.push_back(e);
        case (upd)
            U_ILL:   m_ill = 1'b1;
            U_BUS:   m_bus = 1'b1;
            U_CNT:   m_cnt = (m_cnt + 1) % (1 << CNT_W);
            default: ;
        endcase
    endtask

    task automatic wait_phase(int ph, int stalls, int op, int upd_done, output bit abort);
        int n = (stalls < WAIT_MAX) ? stalls : WAIT_MAX;
        abort = (stalls >= WAIT_MAX);
        for (int i = 0; i < n; i++)
            emit(ph, (op < 0) ? ro() : op, rb(), 1'b0, rb(),
                 (abort && (i == n - 1)) ? U_BUS : U_NONE);
        if (!abort) emit(ph, (op < 0) ? ro() : op, rb(), 1'b1, rb(), upd_done);
    endtask

    task automatic halted(int h);
        for (int i = 0; i < h; i++) emit(8, ro(), rb(), rb(), 1'b0, U_NONE);
        emit(8, ro(), rb(), rb(), 1'b1, U_NONE);
    endtask

    task automatic run_instr(int op, bit z, int s_if, int s_of, int s_st, int h);
        bit ab;
        bit alu = (op >= 2) && (op <= 5);
        killed = 1'b0;
        emit(0, ro(), rb(), rb(), rb(), U_NONE);
        wait_phase(1, s_if, -1, U_NONE, ab);
        if (ab) begin halted(h); return; end
        emit(2, ro(), rb(), rb(), rb(), U_NONE);
        emit(3, ro(), rb(), rb(), rb(), U_NONE);
        if ((op == 0) || (op >= 8)) begin
            emit(4, op, rb(), rb(), rb(), (op >= 8) ? U_ILL : U_NONE);
            halted(h);
            return;
        end
        emit(4, op, rb(), rb(), rb(), U_NONE);
        if (alu) begin
            wait_phase(5, s_of, op, U_NONE, ab);
            if (ab) begin halted(h); return; end
        end else begin
            emit(5, op, rb(), rb(), rb(), U_NONE);
        end
        emit(6, op, z, rb(), rb(), U_NONE);
        if (op == 6) begin
            wait_phase(7, s_st, op, U_CNT, ab);
            if (ab) begin halted(h); return; end
        end else begin
            emit(7, op, rb(), rb(), rb(), U_CNT);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs that are checked against the oldest expectation.
    initial begin
        exp_t e, a;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {phase, {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr},
                     illegal_op, bus_err, instr_count};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle%0d got ph=%0d strb=%b ill=%b bus=%b cnt=%0d required ph=%0d strb=%b ill=%b bus=%b cnt=%0d",
                             cyc, a.ph, a.strb, a.ill, a.bus, a.cnt, e.ph, e.strb, e.ill, e.bus, e.cnt);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int pick_stall();
        return ($urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, 16));
    endfunction

    initial begin
        int op, s1, s2, s3;
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0; run = 1'b0;
        drive_reset();
        run_instr(5, 1'b0, 0, 0, 0, 0);
        run_instr(1, 1'b1, 0, 0, 0, 0);
        run_instr(1, 1'b0, 0, 0, 0, 0);
        run_instr(7, 1'b1, 0, 0, 0, 0);
        run_instr(6, 1'b0, 0, 0, 3, 0);
        run_instr(2, 1'b0, 0, 15, 0, 2);
        run_instr(0, 1'b0, 0, 0, 0, 3);
        run_instr(2, 1'b1, 0, 14, 0, 0);
        run_instr(5, 1'b0, 14, 0, 0, 0);
        run_instr(6, 1'b0, 0, 0, 15, 1);
        kill_in = 7;
        run_instr(9, 1'b0, 0, 0, 0, 5);
        kill_in = 3;
        run_instr(5, 1'b0, 10, 0, 0, 0);
        run_instr(3, 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < 150; k++) begin
            op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(8, 15))
                                              : int'($urandom_range(0, 7));
            s1 = pick_stall();
            s2 = pick_stall();
            s3 = pick_stall();
            if ($urandom_range(0, 24) == 0) kill_in = int'($urandom_range(0, 14));
            run_instr(op, rb(), s1, s2, s3, int'($urandom_range(0, 3)));
        end
        @(negedge clk);
        @(negedge clk);
        #4;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
